// File: rtl/score_loader.sv
// Frame parser: UART bytes -> note memory writes.
// Frame: A5, N, N x (HI, LO), XOR checksum over N and note bytes.
module score_loader #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 104160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [11:0]       mem_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        note_count,
  output logic              load_done,
  output logic              frame_err,
  output logic [2:0]        err_code,
  output logic              busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_CHK
  } state_t;

  state_t        state;
  logic [7:0]    n_len;
  logic [7:0]    x_acc;
  logic [3:0]    hi_nib;
  logic [8:0]    idx;
  logic [TW-1:0] tmo;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n_len      <= '0;
      x_acc      <= '0;
      hi_nib     <= '0;
      idx        <= '0;
      tmo        <= '0;
      mem_wdata  <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      note_count <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      frame_err <= 1'b0;

      // A byte arriving in the expiry cycle wins over the timeout
      if (state == S_IDLE || rx_valid) begin
        tmo <= '0;
      end else if (tmo == TMO_LAST) begin
        tmo       <= '0;
        state     <= S_IDLE;
        frame_err <= 1'b1;
        err_code  <= 3'd4;
      end else begin
        tmo <= tmo + TW'(1);
      end

      if (rx_valid) begin
        unique case (state)
          S_IDLE: begin
            if (rx_data == 8'hA5) begin
              state    <= S_LEN;
              x_acc    <= '0;
              err_code <= '0;
            end
          end
          S_LEN: begin
            n_len <= rx_data;
            x_acc <= rx_data;
            if ({1'b0, rx_data} > DEPTH_W) begin
              frame_err <= 1'b1;
              err_code  <= 3'd2;
              state     <= S_IDLE;
            end else if (rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              idx   <= '0;
              state <= S_HI;
            end
          end
          S_HI: begin
            if (rx_data[7:4] != 4'd0) begin
              frame_err <= 1'b1;
              err_code  <= 3'd1;
              state     <= S_IDLE;
            end else begin
              hi_nib <= rx_data[3:0];
              x_acc  <= x_acc ^ rx_data;
              state  <= S_LO;
            end
          end
          S_LO: begin
            x_acc     <= x_acc ^ rx_data;
            mem_wdata <= {hi_nib, rx_data};
            mem_addr  <= idx[ADDR_W-1:0];
            mem_we    <= 1'b1;
            idx       <= idx + 9'd1;
            if ((idx + 9'd1) == {1'b0, n_len}) state <= S_CHK;
            else state <= S_HI;
          end
          S_CHK: begin
            if (rx_data == x_acc) begin
              note_count <= n_len;
              load_done  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 3'd3;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
